pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage RV32IM pipeline.
- Arbitrates data-memory wait, instruction-memory wait, iterative divider occupancy, branch/jump redirect and load-use hazard.
- Drives hold/reset of the PC and of every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Owns the divider occupancy FSM, a pending-fetch-discard flag and a stall performance counter.

Parameters:
DIV_CYCLES, 32, number of RUN cycles of the iterative div/rem unit (must be ≥1)
CNT_W, 32, width of STALL_CNT

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET  input  1  synchronous, active-high reset
BJ_SIG  input  1  branch taken / jump resolved in EX
LU_HAZ_SIG  input  1  load-use hazard detected in ID
IMEM_BUSY  input  1  instruction fetch not yet returned
DMEM_BUSY  input  1  MEM-stage data access not complete
MDU_START  input  1  div/rem instruction present in EX (level, held while in EX)
PC_HOLD  output  1  PC keeps its value
IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD  output  1 each  register keeps its value
IF_ID_RES, ID_EX_RES, EX_MEM_RES, MEM_WB_RES  output  1 each  register loads bubble
MDU_BUSY  output  1  divider FSM in RUN
MDU_DONE  output  1  divider result valid this cycle (FSM in DONE)
STALL_CNT  output  CNT_W  count of cycles with PC_HOLD=1

Behaviour:
- Hold/reset outputs are combinational from inputs and registered state. MDU_BUSY and MDU_DONE are decoded from FSM state. STALL_CNT is a register.
- RESET=1 cycle: all *_RES=1, all holds=0, MDU_BUSY=0, MDU_DONE=0. Registered state cleared on the edge: FSM IDLE, FP=0, STALL_CNT=0.
- Priority, first matching row wins; outputs not listed are 0.
  1. DMEM_BUSY: PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD, MEM_WB_RES. BJ_SIG, LU_HAZ_SIG and IMEM_BUSY are ignored; the branch stays frozen in EX and is re-evaluated after release.
  2. Div stall, active when (FSM=IDLE and MDU_START) or FSM=RUN: PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, EX_MEM_RES.
  3. BJ_SIG: IF_ID_RES, ID_EX_RES. Additionally, if IMEM_BUSY: PC_HOLD=0 so the target loads, and FP is set.
  4. LU_HAZ_SIG: PC_HOLD, IF_ID_HOLD, ID_EX_RES. IMEM_BUSY is ignored because IF/ID is already held.
  5. IMEM_BUSY: PC_HOLD, IF_ID_RES.
  6. FP=1 and IMEM_BUSY=0 (stale wrong-path fetch returning): PC_HOLD, IF_ID_RES, and FP clears.
- Pending-discard flag FP:
  - Set on any row-3 cycle with IMEM_BUSY=1.
  - Cleared only in row 6 or by RESET.
  - Stays set if BJ_SIG recurs.
  - Row 6 is evaluated only when rows 1–5 do not match. If the return coincides with rows 2–4, FP persists.
- Divider FSM (IDLE, RUN, DONE):
  - IDLE→RUN when MDU_START=1 and DMEM_BUSY=0; count loads DIV_CYCLES-1.
  - RUN: count decrements every cycle regardless of DMEM_BUSY. At count==0 → DONE.
  - DONE: MDU_DONE=1, stall released. → IDLE when DMEM_BUSY=0; otherwise stays in DONE.
  - MDU_START is ignored in RUN and DONE.
  - Latency: MDU_START first seen at cycle t → RUN t+1..t+DIV_CYCLES → DONE at t+DIV_CYCLES+1. Stall duration is DIV_CYCLES+1 cycles.
  - Back-to-back div: the second div asserts MDU_START in the cycle after DONE and restarts from IDLE.
  - RESET mid-RUN: FSM→IDLE and the count is discarded.
- STALL_CNT: +1 on each cycle with PC_HOLD=1 and RESET=0. Saturates at 2^CNT_W-1, no wrap.
- Invariant: HOLD and RES of the same register are never both 1.

Test Plan:
- Reset then idle inputs → all outputs 0, STALL_CNT=0. Raise BJ_SIG for 1 cycle → IF_ID_RES=ID_EX_RES=1 that cycle only.
- MDU_START=1 at cycle 10, DIV_CYCLES=32 → PC_HOLD/IF_ID_HOLD/ID_EX_HOLD/EX_MEM_RES high cycles 10–42, MDU_BUSY 11–42, MDU_DONE at 43, STALL_CNT=33. Second MDU_START at 44 → new 33-cycle stall.
- BJ_SIG with IMEM_BUSY=1 for 3 more cycles → PC_HOLD=0 in the BJ cycle. IF_ID_RES held through the busy cycles. First non-busy cycle: PC_HOLD=1, IF_ID_RES=1, FP clears.
- DMEM_BUSY=1 for 4 cycles with BJ_SIG and LU_HAZ_SIG both 1 → only the row-1 pattern (four holds + MEM_WB_RES). On release with BJ_SIG still 1 → flush applied.
- DMEM_BUSY asserted during div RUN ending after count expiry → FSM stays in DONE, MDU_DONE=1 until DMEM_BUSY falls, then IDLE.
- RESET pulse at RUN count 5 → next cycle MDU_BUSY=0, no stall, STALL_CNT=0. Separately force PC_HOLD for 2^CNT_W cycles with CNT_W=4 → STALL_CNT saturates at 15.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - stall/flush sequencer for the 5-stage RV32IM pipeline
module pipeline_hazard_controller #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             BJ_SIG,
  input  logic             LU_HAZ_SIG,
  input  logic             IMEM_BUSY,
  input  logic             DMEM_BUSY,
  input  logic             MDU_START,
  output logic             PC_HOLD,
  output logic             IF_ID_HOLD,
  output logic             ID_EX_HOLD,
  output logic             EX_MEM_HOLD,
  output logic             IF_ID_RES,
  output logic             ID_EX_RES,
  output logic             EX_MEM_RES,
  output logic             MEM_WB_RES,
  output logic             MDU_BUSY,
  output logic             MDU_DONE,
  output logic [CNT_W-1:0] STALL_CNT
);

  localparam int DCW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [DCW-1:0]   DIV_LOAD = DCW'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [1:0]       state_q, state_d;
  logic [DCW-1:0]   div_cnt_q, div_cnt_d;
  logic             fp_q, fp_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             div_stall;

  // The div stall covers the first-seen cycle in IDLE plus every RUN cycle.
  assign div_stall = ((state_q == ST_IDLE) && MDU_START) || (state_q == ST_RUN);

  // Priority arbitration of hold/bubble controls and the pending-discard flag.
  always_comb begin
    PC_HOLD     = 1'b0;
    IF_ID_HOLD  = 1'b0;
    ID_EX_HOLD  = 1'b0;
    EX_MEM_HOLD = 1'b0;
    IF_ID_RES   = 1'b0;
    ID_EX_RES   = 1'b0;
    EX_MEM_RES  = 1'b0;
    MEM_WB_RES  = 1'b0;
    fp_d        = fp_q;
    if (RESET) begin
      IF_ID_RES  = 1'b1;
      ID_EX_RES  = 1'b1;
      EX_MEM_RES = 1'b1;
      MEM_WB_RES = 1'b1;
      fp_d       = 1'b0;
    end else if (DMEM_BUSY) begin
      // Freeze everything up to MEM; a branch in EX is re-evaluated on release.
      PC_HOLD     = 1'b1;
      IF_ID_HOLD  = 1'b1;
      ID_EX_HOLD  = 1'b1;
      EX_MEM_HOLD = 1'b1;
      MEM_WB_RES  = 1'b1;
    end else if (div_stall) begin
      PC_HOLD    = 1'b1;
      IF_ID_HOLD = 1'b1;
      ID_EX_HOLD = 1'b1;
      EX_MEM_RES = 1'b1;
    end else if (BJ_SIG) begin
      // PC loads the target even with a fetch outstanding; that fetch is stale.
      IF_ID_RES = 1'b1;
      ID_EX_RES = 1'b1;
      if (IMEM_BUSY) begin
        fp_d = 1'b1;
      end
    end else if (LU_HAZ_SIG) begin
      PC_HOLD    = 1'b1;
      IF_ID_HOLD = 1'b1;
      ID_EX_RES  = 1'b1;
    end else if (IMEM_BUSY) begin
      PC_HOLD   = 1'b1;
      IF_ID_RES = 1'b1;
    end else if (fp_q) begin
      // Wrong-path fetch returning now: drop it and keep the PC on the target.
      PC_HOLD   = 1'b1;
      IF_ID_RES = 1'b1;
      fp_d      = 1'b0;
    end
  end

  // Divider occupancy FSM; RUN counts down regardless of memory stalls.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (MDU_START && !DMEM_BUSY) begin
          state_d   = ST_RUN;
          div_cnt_d = DIV_LOAD;
        end
      end
      ST_RUN: begin
        if (div_cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          div_cnt_d = div_cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (!DMEM_BUSY) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stall cycle counter, saturating at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (PC_HOLD && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  assign MDU_BUSY  = !RESET && (state_q == ST_RUN);
  assign MDU_DONE  = !RESET && (state_q == ST_DONE);
  assign STALL_CNT = stall_cnt_q;

  // State registers with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      div_cnt_q   <= '0;
      fp_q        <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      fp_q        <= fp_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - scoreboard bench for pipeline_hazard_controller
module tb_pipeline_hazard_controller;

  // Output vector order: PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD,
  // IF_ID_RES, ID_EX_RES, EX_MEM_RES, MEM_WB_RES, MDU_BUSY, MDU_DONE
  localparam logic [9:0] P_IDLE   = 10'b0000000000;
  localparam logic [9:0] P_RST    = 10'b0000111100;
  localparam logic [9:0] P_DMEM   = 10'b1111000100;
  localparam logic [9:0] P_DSTART = 10'b1110001000;
  localparam logic [9:0] P_RUN    = 10'b1110001010;
  localparam logic [9:0] P_DONE   = 10'b0000000001;
  localparam logic [9:0] P_BJ     = 10'b0000110000;
  localparam logic [9:0] P_LU     = 10'b1100010000;
  localparam logic [9:0] P_IMEM   = 10'b1000100000;

  logic CLK = 1'b0;
  logic RESET, BJ_SIG, LU_HAZ_SIG, IMEM_BUSY, DMEM_BUSY, MDU_START;
  logic PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD;
  logic IF_ID_RES, ID_EX_RES, EX_MEM_RES, MEM_WB_RES, MDU_BUSY, MDU_DONE;
  logic [31:0] STALL_CNT;
  logic s_pc_hold, s_if_id_hold, s_id_ex_hold, s_ex_mem_hold;
  logic s_if_id_res, s_id_ex_res, s_ex_mem_res, s_mem_wb_res, s_mdu_busy, s_mdu_done;
  logic [3:0] s_stall_cnt;

  logic [9:0] obs;
  logic [9:0] exp_q[$];
  logic [31:0] exp_cnt = '0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  assign obs = {PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD,
                IF_ID_RES, ID_EX_RES, EX_MEM_RES, MEM_WB_RES, MDU_BUSY, MDU_DONE};

  pipeline_hazard_controller #(.DIV_CYCLES(32), .CNT_W(32)) dut (
    .CLK(CLK), .RESET(RESET), .BJ_SIG(BJ_SIG), .LU_HAZ_SIG(LU_HAZ_SIG),
    .IMEM_BUSY(IMEM_BUSY), .DMEM_BUSY(DMEM_BUSY), .MDU_START(MDU_START),
    .PC_HOLD(PC_HOLD), .IF_ID_HOLD(IF_ID_HOLD), .ID_EX_HOLD(ID_EX_HOLD),
    .EX_MEM_HOLD(EX_MEM_HOLD), .IF_ID_RES(IF_ID_RES), .ID_EX_RES(ID_EX_RES),
    .EX_MEM_RES(EX_MEM_RES), .MEM_WB_RES(MEM_WB_RES), .MDU_BUSY(MDU_BUSY),
    .MDU_DONE(MDU_DONE), .STALL_CNT(STALL_CNT)
  );

  pipeline_hazard_controller #(.DIV_CYCLES(1), .CNT_W(4)) dut_sat (
    .CLK(CLK), .RESET(RESET), .BJ_SIG(BJ_SIG), .LU_HAZ_SIG(LU_HAZ_SIG),
    .IMEM_BUSY(IMEM_BUSY), .DMEM_BUSY(DMEM_BUSY), .MDU_START(MDU_START),
    .PC_HOLD(s_pc_hold), .IF_ID_HOLD(s_if_id_hold), .ID_EX_HOLD(s_id_ex_hold),
    .EX_MEM_HOLD(s_ex_mem_hold), .IF_ID_RES(s_if_id_res), .ID_EX_RES(s_id_ex_res),
    .EX_MEM_RES(s_ex_mem_res), .MEM_WB_RES(s_mem_wb_res), .MDU_BUSY(s_mdu_busy),
    .MDU_DONE(s_mdu_done), .STALL_CNT(s_stall_cnt)
  );

  task automatic drive(input logic bj, input logic lu, input logic imem,
                       input logic dmem, input logic st, input logic rst);
    BJ_SIG = bj; LU_HAZ_SIG = lu; IMEM_BUSY = imem;
    DMEM_BUSY = dmem; MDU_START = st; RESET = rst;
  endtask

  // Close the cycle: track the expected stall count, then move past the edge.
  task automatic advance(input logic [9:0] e);
    if (RESET) exp_cnt = '0;
    else if (e[9]) exp_cnt = exp_cnt + 1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    logic [9:0] e;
    drive(0, 0, 0, 0, 0, 1);
    @(posedge CLK);
    #1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, (i < 2));
      exp_q.push_back((i < 2) ? P_RST : P_IDLE);
      @(negedge CLK);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL reset step %0d: observed %b expected %b", i, obs, e);
      end
      n_cmp++;
      if (STALL_CNT !== 32'd0) begin
        n_bad++;
        $display("FAIL reset_stall_cnt step %0d: observed %0d expected 0", i, STALL_CNT);
      end
      advance(e);
    end
  endtask

  task automatic test_branch;
    logic [9:0] e;
    logic [31:0] base;
    base = exp_cnt;
    for (int i = 0; i < 2; i++) begin
      drive((i == 0), 0, 0, 0, 0, 0);
      exp_q.push_back((i == 0) ? P_BJ : P_IDLE);
      @(negedge CLK);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL branch step %0d: observed %b expected %b", i, obs, e);
      end
      advance(e);
    end
    n_cmp++;
    if (STALL_CNT !== base) begin
      n_bad++;
      $display("FAIL branch_stall_cnt: observed %0d expected %0d", STALL_CNT, base);
    end
  endtask

  task automatic test_div_back_to_back;
    logic [9:0] e;
    logic [31:0] base;
    base = exp_cnt;
    for (int i = 0; i <= 68; i++) begin
      drive(0, 0, 0, 0, (i <= 67), 0);
      if (i == 68) exp_q.push_back(P_IDLE);
      else if (i % 34 == 0) exp_q.push_back(P_DSTART);
      else if (i % 34 == 33) exp_q.push_back(P_DONE);
      else exp_q.push_back(P_RUN);
      @(negedge CLK);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL div step %0d: observed %b expected %b", i, obs, e);
      end
      if (i == 34) begin
        n_cmp++;
        if (STALL_CNT !== base + 32'd33) begin
          n_bad++;
          $display("FAIL div_stall_cnt first: observed %0d expected %0d", STALL_CNT, base + 32'd33);
        end
      end
      advance(e);
    end
    n_cmp++;
    if (STALL_CNT !== base + 32'd66) begin
      n_bad++;
      $display("FAIL div_stall_cnt second: observed %0d expected %0d", STALL_CNT, base + 32'd66);
    end
  endtask

  task automatic test_fetch_discard;
    logic [9:0] e;
    for (int i = 0; i < 10; i++) begin
      case (i)
        0: begin drive(1, 0, 1, 0, 0, 0); exp_q.push_back(P_BJ);   end
        1, 2, 3: begin drive(0, 0, 1, 0, 0, 0); exp_q.push_back(P_IMEM); end
        4: begin drive(0, 0, 0, 0, 0, 0); exp_q.push_back(P_IMEM); end
        5: begin drive(0, 0, 0, 0, 0, 0); exp_q.push_back(P_IDLE); end
        6: begin drive(1, 0, 1, 0, 0, 0); exp_q.push_back(P_BJ);   end
        7: begin drive(0, 1, 0, 0, 0, 0); exp_q.push_back(P_LU);   end
        8: begin drive(0, 0, 0, 0, 0, 0); exp_q.push_back(P_IMEM); end
        default: begin drive(0, 0, 0, 0, 0, 0); exp_q.push_back(P_IDLE); end
      endcase
      @(negedge CLK);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL fetch_discard step %0d: observed %b expected %b", i, obs, e);
      end
      advance(e);
    end
  endtask

  task automatic test_dmem_priority;
    logic [9:0] e;
    for (int i = 0; i < 6; i++) begin
      drive((i <= 4), (i <= 4), (i <= 3), (i <= 3), 0, 0);
      if (i <= 3) exp_q.push_back(P_DMEM);
      else if (i == 4) exp_q.push_back(P_BJ);
      else exp_q.push_back(P_IDLE);
      @(negedge CLK);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL dmem_priority step %0d: observed %b expected %b", i, obs, e);
      end
      advance(e);
    end
    n_cmp++;
    if (STALL_CNT !== exp_cnt) begin
      n_bad++;
      $display("FAIL dmem_stall_cnt: observed %0d expected %0d", STALL_CNT, exp_cnt);
    end
  endtask

  task automatic test_div_dmem_done;
    logic [9:0] e;
    logic dm;
    for (int j = 0; j <= 38; j++) begin
      dm = (j == 0) || (j >= 31 && j <= 36);
      drive(0, 0, 0, dm, (j <= 37), 0);
      if (j == 0) exp_q.push_back(P_DMEM);
      else if (j == 1) exp_q.push_back(P_DSTART);
      else if (j <= 33) exp_q.push_back(dm ? (P_DMEM | 10'b10) : P_RUN);
      else if (j <= 37) exp_q.push_back(dm ? (P_DMEM | 10'b01) : P_DONE);
      else exp_q.push_back(P_IDLE);
      @(negedge CLK);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL div_dmem step %0d: observed %b expected %b", j, obs, e);
      end
      advance(e);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [9:0] e;
    for (int i = 0; i < 9; i++) begin
      drive(0, 0, 0, 0, (i <= 6), (i == 6));
      if (i == 0) exp_q.push_back(P_DSTART);
      else if (i <= 5) exp_q.push_back(P_RUN);
      else if (i == 6) exp_q.push_back(P_RST);
      else exp_q.push_back(P_IDLE);
      @(negedge CLK);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL reset_mid_run step %0d: observed %b expected %b", i, obs, e);
      end
      if (i == 7) begin
        n_cmp++;
        if (STALL_CNT !== 32'd0) begin
          n_bad++;
          $display("FAIL reset_mid_run_cnt: observed %0d expected 0", STALL_CNT);
        end
      end
      advance(e);
    end
  endtask

  task automatic test_saturation;
    logic [9:0] e;
    for (int i = 0; i <= 20; i++) begin
      drive(0, (i >= 1), 0, 0, 0, (i == 0));
      exp_q.push_back((i == 0) ? P_RST : P_LU);
      @(negedge CLK);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL saturation step %0d: observed %b expected %b", i, obs, e);
      end
      if (i == 15) begin
        n_cmp++;
        if (s_stall_cnt !== 4'd14) begin
          n_bad++;
          $display("FAIL sat_cnt_pre: observed %0d expected 14", s_stall_cnt);
        end
      end
      if (i == 16) begin
        n_cmp++;
        if (s_stall_cnt !== 4'd15) begin
          n_bad++;
          $display("FAIL sat_cnt_at: observed %0d expected 15", s_stall_cnt);
        end
      end
      advance(e);
    end
    drive(0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    n_cmp++;
    if (s_stall_cnt !== 4'd15) begin
      n_bad++;
      $display("FAIL sat_cnt_hold: observed %0d expected 15", s_stall_cnt);
    end
    n_cmp++;
    if (STALL_CNT !== 32'd20) begin
      n_bad++;
      $display("FAIL sat_wide_cnt: observed %0d expected 20", STALL_CNT);
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_branch;
    test_div_back_to_back;
    test_fetch_discard;
    test_dmem_priority;
    test_div_dmem_done;
    test_reset_mid_run;
    test_saturation;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
